// File: rtl/spi_frame_rx_if.sv
// SPI pins and pixel write stream between the Pi-facing receiver and the frame buffer.
interface spi_frame_rx_if #(
  parameter int unsigned CDEPTH = 4,
  parameter int unsigned AW     = 10
);
  localparam int unsigned PW = 3 * CDEPTH;

  logic          sck;
  logic          sdi;
  logic          cs_n;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic [AW-1:0] pix_addr;
  logic          frame_done;
  logic          frame_err;
  logic          busy;

  modport slave (
    input  sck, sdi, cs_n,
    output pix_valid, pix_data, pix_addr, frame_done, frame_err, busy
  );

  modport master (
    output sck, sdi, cs_n,
    input  pix_valid, pix_data, pix_addr, frame_done, frame_err, busy
  );
endinterface

// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver: turns one cs_n window of packed RGB pixels into
// addressed pixel writes, flagging complete frames with frame_done.
module spi_frame_rx #(
  parameter int unsigned CDEPTH = 4,
  parameter int unsigned NPIX   = 1024,
  parameter int unsigned AW     = 10
) (
  input  logic            clk,
  input  logic            reset,
  spi_frame_rx_if.slave   io_bus
);
  localparam int unsigned PW  = 3 * CDEPTH;
  localparam int unsigned BW  = $clog2(PW);
  localparam int unsigned PCW = AW + 1;

  typedef enum logic [1:0] {WAIT_HI, IDLE, RECV, OVERRUN} state_t;

  state_t          r_state, w_state_nxt;

  logic            r_sck_s1, r_sck_s2, r_sck_s3;
  logic            r_sdi_s1, r_sdi_s2;
  logic            r_cs_s1, r_cs_s2, r_cs_s3;
  logic            r_sck_rise, r_bit, r_cs_rise, r_cs_fall, r_cs_lvl;
  logic [1:0]      r_hi_cnt;

  logic [BW-1:0]   r_bcnt;
  logic [PCW-1:0]  r_pcnt;
  logic [PW-2:0]   r_sr;
  logic            r_pix_valid, r_frame_done, r_frame_err, r_busy;
  logic [PW-1:0]   r_pix_data;
  logic [AW-1:0]   r_pix_addr;

  logic            w_full, w_cs_quiet_hi;
  logic            w_start, w_take, w_last, w_done, w_err;

  // Synchronisers plus one registered event stage; sdi shares the sck depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_s1   <= 1'b0; r_sck_s2 <= 1'b0; r_sck_s3 <= 1'b0;
      r_sdi_s1   <= 1'b0; r_sdi_s2 <= 1'b0;
      r_cs_s1    <= 1'b1; r_cs_s2  <= 1'b1; r_cs_s3  <= 1'b1;
      r_sck_rise <= 1'b0;
      r_bit      <= 1'b0;
      r_cs_rise  <= 1'b0;
      r_cs_fall  <= 1'b0;
      r_cs_lvl   <= 1'b1;
    end else begin
      r_sck_s1   <= io_bus.sck;  r_sck_s2 <= r_sck_s1; r_sck_s3 <= r_sck_s2;
      r_sdi_s1   <= io_bus.sdi;  r_sdi_s2 <= r_sdi_s1;
      r_cs_s1    <= io_bus.cs_n; r_cs_s2  <= r_cs_s1;  r_cs_s3  <= r_cs_s2;
      r_sck_rise <= r_sck_s2 & ~r_sck_s3;
      r_bit      <= r_sdi_s2;
      r_cs_rise  <= r_cs_s2 & ~r_cs_s3;
      r_cs_fall  <= ~r_cs_s2 & r_cs_s3;
      r_cs_lvl   <= r_cs_s2;
    end
  end

  assign w_full        = (r_pcnt == PCW'(NPIX));
  // cs_n must read high through the whole pipeline, so reset values alone never release WAIT_HI.
  assign w_cs_quiet_hi = r_cs_s1 & r_cs_s2 & r_cs_s3 & r_cs_lvl;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_HI;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_HI: if (w_cs_quiet_hi && (r_hi_cnt == 2'd3)) w_state_nxt = IDLE;
      IDLE:    if (r_cs_fall) w_state_nxt = RECV;
      RECV: begin
        if (r_cs_rise)                  w_state_nxt = IDLE;
        else if (r_sck_rise && w_full)  w_state_nxt = OVERRUN;
      end
      OVERRUN: if (r_cs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = WAIT_HI;
    endcase
  end

  // Output decode; a last bit coinciding with cs_n rise completes before the frame check.
  always_comb begin
    w_start = 1'b0;
    w_take  = 1'b0;
    w_last  = 1'b0;
    w_done  = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: w_start = r_cs_fall;
      RECV: begin
        w_take = r_sck_rise & ~w_full;
        w_last = w_take & (r_bcnt == BW'(PW - 1));
        if (r_cs_rise) begin
          if ((w_last && (r_pcnt == PCW'(NPIX - 1))) ||
              (!r_sck_rise && w_full && (r_bcnt == '0)))
            w_done = 1'b1;
          else
            w_err  = 1'b1;
        end
      end
      OVERRUN: w_err = r_cs_rise;
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi_cnt     <= '0;
      r_bcnt       <= '0;
      r_pcnt       <= '0;
      r_sr         <= '0;
      r_pix_valid  <= 1'b0;
      r_pix_data   <= '0;
      r_pix_addr   <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_pix_valid  <= w_last;
      r_frame_done <= w_done;
      r_frame_err  <= w_err;
      r_busy       <= (w_state_nxt == RECV) || (w_state_nxt == OVERRUN);

      if ((r_state == WAIT_HI) && w_cs_quiet_hi) begin
        if (r_hi_cnt != 2'd3) r_hi_cnt <= r_hi_cnt + 2'd1;
      end else begin
        r_hi_cnt <= '0;
      end

      if (w_start) begin
        r_bcnt <= '0;
        r_pcnt <= '0;
        r_sr   <= '0;
      end else if (w_last) begin
        r_pix_data <= {r_sr, r_bit};
        r_pix_addr <= r_pcnt[AW-1:0];
        r_bcnt     <= '0;
        r_pcnt     <= r_pcnt + PCW'(1);
      end else if (w_take) begin
        r_sr   <= {r_sr[PW-3:0], r_bit};
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end

  assign io_bus.pix_valid  = r_pix_valid;
  assign io_bus.pix_data   = r_pix_data;
  assign io_bus.pix_addr   = r_pix_addr;
  assign io_bus.frame_done = r_frame_done;
  assign io_bus.frame_err  = r_frame_err;
  assign io_bus.busy       = r_busy;
endmodule

// File: tb/tb_spi_frame_rx.sv
// Scoreboard bench for spi_frame_rx: driver pushes expected pixels/frame events,
// a negedge monitor pops and compares whatever the receiver emits.
module tb_spi_frame_rx;
  localparam int unsigned CDEPTH = 4;
  localparam int unsigned NPIX   = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned PW     = 3 * CDEPTH;

  typedef struct {
    logic [PW-1:0] data;
    logic [AW-1:0] addr;
  } pix_t;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_frame_rx_if #(.CDEPTH(CDEPTH), .AW(AW)) bus ();

  spi_frame_rx #(.CDEPTH(CDEPTH), .NPIX(NPIX), .AW(AW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  pix_t pix_q[$];
  int   ev_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe/pulse must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.pix_valid) begin
        if (pix_q.size() == 0) begin
          check("pix_unexpected", 32'(1), 32'(0));
        end else begin
          pix_t p;
          p = pix_q.pop_front();
          check("pix_data", 32'(bus.pix_data), 32'(p.data));
          check("pix_addr", 32'(bus.pix_addr), 32'(p.addr));
        end
      end
      if (bus.frame_done || bus.frame_err) begin
        check("frame_exclusive", 32'(bus.frame_done & bus.frame_err), 32'(0));
        if (ev_q.size() == 0) begin
          check("frame_unexpected", 32'(1), 32'(0));
        end else begin
          int e;
          e = ev_q.pop_front();
          check("frame_kind", bus.frame_done ? 32'(EV_DONE) : 32'(EV_ERR), 32'(e));
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    bus.sdi = b;
    tick(4);
    bus.sck = 1'b1;
    tick(4);
    bus.sck = 1'b0;
  endtask

  task automatic send_pix(input logic [PW-1:0] d);
    for (int i = PW - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic cs_low();
    bus.cs_n = 1'b0;
    tick(8);
  endtask

  task automatic cs_high();
    tick(8);
    bus.cs_n = 1'b1;
    tick(16);
  endtask

  function automatic logic [PW-1:0] pdat(input int i, input int v);
    if (v == 0) return PW'(i);
    return PW'(i * 273 + 53);
  endfunction

  task automatic drain(input string name);
    check({name, "_pix_drain"}, 32'(pix_q.size()), 32'(0));
    check({name, "_ev_drain"},  32'(ev_q.size()),  32'(0));
  endtask

  // One cs_n window: npix pixels then extra_bits ones; expectations pushed up front.
  task automatic frame(input int npix, input int extra_bits, input int v, input string name);
    for (int i = 0; i < npix && i < int'(NPIX); i++) begin
      pix_t p;
      p.data = pdat(i, v);
      p.addr = AW'(i);
      pix_q.push_back(p);
    end
    ev_q.push_back((npix == int'(NPIX) && extra_bits == 0) ? EV_DONE : EV_ERR);
    cs_low();
    check({name, "_busy"}, 32'(bus.busy), 32'(1));
    for (int i = 0; i < npix; i++) send_pix(pdat(i, v));
    for (int i = 0; i < extra_bits; i++) send_bit(1'b1);
    cs_high();
    check({name, "_idle_busy"}, 32'(bus.busy), 32'(0));
    drain(name);
  endtask

  initial begin
    reset    = 1'b1;
    bus.sck  = 1'b0;
    bus.sdi  = 1'b0;
    bus.cs_n = 1'b1;
    tick(3);
    check("rst_pix_valid",  32'(bus.pix_valid),  32'(0));
    check("rst_frame_done", 32'(bus.frame_done), 32'(0));
    check("rst_frame_err",  32'(bus.frame_err),  32'(0));
    check("rst_busy",       32'(bus.busy),       32'(0));
    check("rst_pix_data",   32'(bus.pix_data),   32'(0));
    check("rst_pix_addr",   32'(bus.pix_addr),   32'(0));
    reset = 1'b0;
    tick(12);

    // T1 full frame, T2 short frame then good frame, T3 overlong frames
    frame(NPIX, 0, 0, "t1");
    frame(NPIX - 1, 0, 1, "t2_short");
    frame(NPIX, 0, 1, "t2_good");
    frame(NPIX, 5, 0, "t3_bits");
    frame(NPIX + 1, 0, 1, "t3_pix");

    // T4 reset mid-window; the remainder of the window must produce nothing
    for (int i = 0; i < 5; i++) begin
      pix_t p;
      p.data = pdat(i, 1);
      p.addr = AW'(i);
      pix_q.push_back(p);
    end
    cs_low();
    for (int i = 0; i < 5; i++) send_pix(pdat(i, 1));
    for (int i = PW - 1; i >= 6; i--) send_bit(pdat(5, 1)[i]);
    reset = 1'b1;
    tick(2);
    check("t4_rst_busy",  32'(bus.busy),      32'(0));
    check("t4_rst_valid", 32'(bus.pix_valid), 32'(0));
    reset = 1'b0;
    for (int i = 5; i >= 0; i--) send_bit(pdat(5, 1)[i]);
    for (int i = 6; i < int'(NPIX); i++) send_pix(pdat(i, 1));
    check("t4_wait_busy", 32'(bus.busy), 32'(0));
    cs_high();
    drain("t4_torn");
    frame(NPIX, 0, 0, "t4_next");

    // T5 single pixel 0xA5C with exact strobe latency
    begin
      logic [PW-1:0] d;
      pix_t p;
      d = 12'hA5C;
      p.data = d;
      p.addr = '0;
      pix_q.push_back(p);
      ev_q.push_back(EV_ERR);
      cs_low();
      for (int i = PW - 1; i >= 1; i--) send_bit(d[i]);
      bus.sdi = d[0];
      tick(4);
      bus.sck = 1'b1;
      @(posedge clk);   // edge k
      @(posedge clk);   // k+1
      @(posedge clk);   // k+2
      @(negedge clk);
      check("t5_lat_early", 32'(bus.pix_valid), 32'(0));
      @(posedge clk);   // k+3
      @(negedge clk);
      check("t5_lat", 32'(bus.pix_valid), 32'(1));
      check("t5_busy", 32'(bus.busy), 32'(1));
      @(posedge clk);
      #1;
      bus.sck = 1'b0;
      cs_high();
      drain("t5");
    end

    // T6 sck activity with cs_n high, then quiet idle
    for (int i = 0; i < 24; i++) begin
      bus.sdi = i[0] ^ i[2];
      bus.sck = ~bus.sck;
      tick(2);
    end
    bus.sck = 1'b0;
    check("t6_busy_toggle", 32'(bus.busy), 32'(0));
    tick(60);
    check("t6_busy_idle", 32'(bus.busy), 32'(0));
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
